// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO responder.
// Build with MDIO_RESP_PRESUP_EN defined to enable preamble suppression.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_PRE,
    S_ST1,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA
  } mdio_state_e;

  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;

  localparam logic [4:0] BMCR  = 5'd0;
  localparam logic [4:0] BMSR  = 5'd1;
  localparam logic [4:0] ID1   = 5'd2;
  localparam logic [4:0] ID2   = 5'd3;
  localparam logic [4:0] ANAR  = 5'd4;
  localparam logic [4:0] GBCR  = 5'd9;
  localparam logic [4:0] PHYSR = 5'd17;

  localparam logic [15:0] BMCR_RST  = 16'h1140;
  localparam logic [15:0] ANAR_RST  = 16'h01E1;
  localparam logic [15:0] GBCR_RST  = 16'h0200;
  // BMSR with the link (bit 2) and preamble-suppression (bit 6) bits cleared.
  localparam logic [15:0] BMSR_BASE = 16'h7909;

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizers for MDC/MDIO and a registered MDC rising-edge strobe.
// mdio_bit_o is delayed to line up with rise_o.
module mdio_sync_edge
  import mdio_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic rise_o,
  output logic mdio_bit_o
);

  logic [1:0] mdc_sync_q;
  logic [1:0] mdio_sync_q;
  logic       mdc_prev_q;
  logic       rise_q;
  logic       mdio_bit_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mdc_sync_q  <= 2'b00;
      mdio_sync_q <= 2'b11;
      mdc_prev_q  <= 1'b0;
      rise_q      <= 1'b0;
      mdio_bit_q  <= 1'b1;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[0], mdc_i};
      mdio_sync_q <= {mdio_sync_q[0], mdio_i};
      mdc_prev_q  <= mdc_sync_q[1];
      rise_q      <= mdc_sync_q[1] & ~mdc_prev_q;
      mdio_bit_q  <= mdio_sync_q[1];
    end
  end

  assign rise_o     = rise_q;
  assign mdio_bit_o = mdio_bit_q;

endmodule

// File: rtl/mdio_resp.sv
// Clause-22 MDIO responder (PHY side) with a small RTL8211E-like register file.
// Optional: MDIO_RESP_PRESUP_EN enables preamble suppression and sets BMSR[6].
module mdio_resp
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter int          PRE_LEN  = 32,
  parameter logic [15:0] PHY_ID1  = 16'h001C,
  parameter logic [15:0] PHY_ID2  = 16'hC915,
  parameter int          SRST_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        link_i,
  input  logic [1:0]  speed_i,
  input  logic        duplex_i,
  output logic        wr_stb_o,
  output logic [4:0]  wr_reg_o,
  output logic [15:0] wr_dat_o,
  output logic        frame_err_o,
  output logic [2:0]  dbg_state_o
);

  localparam logic [5:0]  PRE_MAX = 6'(PRE_LEN);
  localparam logic [15:0] SRST_LD = 16'(SRST_CYC - 1);

  logic rise, mdio_bit;

  mdio_sync_edge u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .mdc_i      (mdc_i),
    .mdio_i     (mdio_i),
    .rise_o     (rise),
    .mdio_bit_o (mdio_bit)
  );

  mdio_state_e state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  phyad_q, phyad_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] shift_q, shift_d;
  logic        match_q, match_d;
  logic        mdio_q, mdio_d;
  logic        oe_q, oe_d;
  logic        wr_stb_q, wr_stb_d;
  logic [4:0]  wr_reg_q, wr_reg_d;
  logic [15:0] wr_dat_q, wr_dat_d;
  logic        err_q, err_d;
  logic [15:0] reg0_q, reg4_q, reg9_q, srst_cnt_q;
  logic [15:0] rd_data, wdat;
  logic [1:0]  op_now;
  logic        commit, done, presup_ok, presup_bit;

  assign op_now = {op_q[0], mdio_bit};
  assign wdat   = {shift_q[14:0], mdio_bit};

`ifdef MDIO_RESP_PRESUP_EN
  logic presup_q;
  // Armed by any completed frame; consumed by the next ST or lost on an error.
  always_ff @(posedge clk_i) begin
    if (rst_i) presup_q <= 1'b0;
    else if (done) presup_q <= 1'b1;
    else if (err_d || (state_q == S_PRE && state_d == S_ST1)) presup_q <= 1'b0;
  end
  assign presup_ok  = presup_q;
  assign presup_bit = 1'b1;
`else
  assign presup_ok  = 1'b0;
  assign presup_bit = 1'b0;
`endif

  always_comb begin
    rd_data = 16'h0000;
    case (regad_q)
      BMCR:  rd_data = reg0_q;
      BMSR:  begin
        rd_data    = BMSR_BASE;
        rd_data[2] = link_i;
        rd_data[6] = presup_bit;
      end
      ID1:   rd_data = PHY_ID1;
      ID2:   rd_data = PHY_ID2;
      ANAR:  rd_data = reg4_q;
      GBCR:  rd_data = reg9_q;
      PHYSR: rd_data = {speed_i, duplex_i, 2'b00, link_i, 10'b0};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    bit_cnt_d = bit_cnt_q;
    op_d      = op_q;
    phyad_d   = phyad_q;
    regad_d   = regad_q;
    shift_d   = shift_q;
    match_d   = match_q;
    mdio_d    = mdio_q;
    oe_d      = oe_q;
    wr_stb_d  = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_dat_d  = wr_dat_q;
    err_d     = 1'b0;
    commit    = 1'b0;
    done      = 1'b0;
    if (rise) begin
      case (state_q)
        S_PRE: begin
          if (mdio_bit) begin
            if (pre_cnt_q < PRE_MAX) pre_cnt_d = pre_cnt_q + 6'd1;
          end else if (pre_cnt_q >= PRE_MAX || presup_ok) begin
            state_d   = S_ST1;
            pre_cnt_d = 6'd0;
          end else begin
            pre_cnt_d = 6'd0;
          end
        end
        S_ST1: begin
          bit_cnt_d = 5'd0;
          if (mdio_bit) state_d = S_OP;
          else begin
            err_d   = 1'b1;
            state_d = S_PRE;
          end
        end
        S_OP: begin
          if (bit_cnt_q == 5'd0) begin
            op_d      = {1'b0, mdio_bit};
            bit_cnt_d = 5'd1;
          end else begin
            op_d      = op_now;
            bit_cnt_d = 5'd0;
            if (op_now == OP_RD || op_now == OP_WR) state_d = S_PHYAD;
            else begin
              err_d   = 1'b1;
              state_d = S_PRE;
            end
          end
        end
        S_PHYAD: begin
          phyad_d   = {phyad_q[3:0], mdio_bit};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd4) begin
            match_d   = ({phyad_q[3:0], mdio_bit} == PHY_ADDR);
            bit_cnt_d = 5'd0;
            state_d   = S_REGAD;
          end
        end
        S_REGAD: begin
          regad_d   = {regad_q[3:0], mdio_bit};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = 5'd0;
            state_d   = S_TA;
          end
        end
        S_TA: begin
          if (bit_cnt_q == 5'd0) begin
            shift_d   = {15'd0, mdio_bit};
            bit_cnt_d = 5'd1;
          end else begin
            bit_cnt_d = 5'd0;
            if (op_q == OP_RD) begin
              // Snapshot the register here so the whole frame sees one value.
              shift_d = rd_data;
              state_d = S_DATA;
              if (match_q) begin
                oe_d   = 1'b1;
                mdio_d = 1'b0;
              end
            end else if ({shift_q[0], mdio_bit} == 2'b10) begin
              shift_d = 16'd0;
              state_d = S_DATA;
            end else begin
              err_d   = 1'b1;
              state_d = S_PRE;
            end
          end
        end
        S_DATA: begin
          if (op_q == OP_RD) begin
            if (bit_cnt_q == 5'd16) begin
              oe_d      = 1'b0;
              mdio_d    = 1'b1;
              done      = 1'b1;
              pre_cnt_d = 6'd0;
              state_d   = S_PRE;
            end else begin
              if (match_q) mdio_d = shift_q[15];
              shift_d   = {shift_q[14:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else begin
            shift_d   = wdat;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd15) begin
              if (match_q) begin
                commit   = 1'b1;
                wr_stb_d = 1'b1;
                wr_reg_d = regad_q;
                wr_dat_d = wdat;
              end
              done      = 1'b1;
              pre_cnt_d = 6'd0;
              state_d   = S_PRE;
            end
          end
        end
        default: state_d = S_PRE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_PRE;
      pre_cnt_q <= 6'd0;
      bit_cnt_q <= 5'd0;
      op_q      <= 2'b00;
      phyad_q   <= 5'd0;
      regad_q   <= 5'd0;
      shift_q   <= 16'd0;
      match_q   <= 1'b0;
      mdio_q    <= 1'b1;
      oe_q      <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_reg_q  <= 5'd0;
      wr_dat_q  <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      op_q      <= op_d;
      phyad_q   <= phyad_d;
      regad_q   <= regad_d;
      shift_q   <= shift_d;
      match_q   <= match_d;
      mdio_q    <= mdio_d;
      oe_q      <= oe_d;
      wr_stb_q  <= wr_stb_d;
      wr_reg_q  <= wr_reg_d;
      wr_dat_q  <= wr_dat_d;
      err_q     <= err_d;
    end
  end

  // Soft reset: BMCR[15] holds for SRST_CYC cycles, then the writable set reloads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg0_q     <= BMCR_RST;
      reg4_q     <= ANAR_RST;
      reg9_q     <= GBCR_RST;
      srst_cnt_q <= 16'd0;
    end else begin
      if (reg0_q[15]) begin
        if (srst_cnt_q == 16'd0) begin
          reg0_q <= BMCR_RST;
          reg4_q <= ANAR_RST;
          reg9_q <= GBCR_RST;
        end else begin
          srst_cnt_q <= srst_cnt_q - 16'd1;
        end
      end
      if (commit) begin
        case (regad_q)
          BMCR: begin
            reg0_q <= wdat;
            if (wdat[15]) srst_cnt_q <= SRST_LD;
          end
          ANAR:    reg4_q <= wdat;
          GBCR:    reg9_q <= wdat;
          default: ;
        endcase
      end
    end
  end

  assign mdio_o      = mdio_q;
  assign mdio_oe     = oe_q;
  assign wr_stb_o    = wr_stb_q;
  assign wr_reg_o    = wr_reg_q;
  assign wr_dat_o    = wr_dat_q;
  assign frame_err_o = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdio_resp.sv
// Directed bench for mdio_resp acting as the MDIO master (MDC = clk/8).
// Expectations for the preamble-suppression build follow MDIO_RESP_PRESUP_EN.
module tb_mdio_resp;

  localparam int SRST = 1500;

  logic        clk = 1'b0;
  logic        rst_i, mdc_i, mdio_i, link_i, duplex_i;
  logic [1:0]  speed_i;
  logic        mdio_o, mdio_oe, wr_stb_o, frame_err_o;
  logic [4:0]  wr_reg_o;
  logic [15:0] wr_dat_o;
  logic [2:0]  dbg_state_o;

  int n_chk = 0, n_fail = 0;
  int stb_cnt = 0, err_cnt = 0, oe_cnt = 0;

  mdio_resp #(.SRST_CYC(SRST)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .mdc_i       (mdc_i),
    .mdio_i      (mdio_i),
    .mdio_o      (mdio_o),
    .mdio_oe     (mdio_oe),
    .link_i      (link_i),
    .speed_i     (speed_i),
    .duplex_i    (duplex_i),
    .wr_stb_o    (wr_stb_o),
    .wr_reg_o    (wr_reg_o),
    .wr_dat_o    (wr_dat_o),
    .frame_err_o (frame_err_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Pulse and drive monitors, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_stb_o === 1'b1) stb_cnt++;
    if (frame_err_o === 1'b1) err_cnt++;
    if (mdio_oe === 1'b1) oe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One MDC period: drive b in the low phase, sample the pad just before the rise.
  task automatic mdc_cycle(input logic b, output logic s, output logic o);
    mdio_i = b;
    repeat (4) @(negedge clk);
    s = mdio_o;
    o = mdio_oe;
    mdc_i = 1'b1;
    repeat (4) @(negedge clk);
    mdc_i = 1'b0;
  endtask

  task automatic idle(input int n);
    mdio_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Full frame. abort_bit >= 0 asserts rst_i right after that read data bit is driven.
  task automatic run_frame(input int npre, input logic [1:0] op, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd, input int abort_bit,
                           output logic [15:0] rd, output logic oe1, output logic oe2,
                           output logic oe_pre, output logic oe_post);
    logic [13:0] hdr;
    logic s, o;
    rd = 16'hxxxx; oe1 = 1'bx; oe2 = 1'bx; oe_pre = 1'bx; oe_post = 1'bx;
    hdr = {2'b01, op, pa, ra};
    for (int i = 0; i < npre; i++) mdc_cycle(1'b1, s, o);
    for (int i = 13; i >= 0; i--) mdc_cycle(hdr[i], s, o);
    if (op == 2'b10) begin
      mdc_cycle(1'b1, s, o);
      mdc_cycle(1'b1, s, o); oe1 = o;
      for (int j = 0; j <= 16; j++) begin
        mdc_cycle(1'b1, s, o);
        if (j == 0) oe2 = o;
        else rd[16 - j] = s;
        if (abort_bit >= 0 && j == 15 - abort_bit) begin
          oe_pre = mdio_oe;
          rst_i = 1'b1;
          @(negedge clk);
          oe_post = mdio_oe;
          rst_i = 1'b0;
          return;
        end
      end
    end else begin
      mdc_cycle(1'b1, s, o); oe1 = o;
      mdc_cycle(1'b0, s, o); oe2 = o;
      for (int i = 15; i >= 0; i--) mdc_cycle(wd[i], s, o);
    end
  endtask

  logic [15:0] rd;
  logic        oe1, oe2, oep, oeq, s0, o0;
  int          stb0, err0, oe0;
  logic [15:0] exp_bmsr, exp_reg4;
  int          exp_b2b;

  initial begin
`ifdef MDIO_RESP_PRESUP_EN
    exp_bmsr = 16'h7949; exp_reg4 = 16'h0BBB; exp_b2b = 2;
`else
    exp_bmsr = 16'h7909; exp_reg4 = 16'h01E1; exp_b2b = 1;
`endif
    rst_i = 1'b1; mdc_i = 1'b0; mdio_i = 1'b1;
    link_i = 1'b0; speed_i = 2'b00; duplex_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mdio_o", mdio_o, 1);
    chk("rst_mdio_oe", mdio_oe, 0);
    chk("rst_wr_stb", wr_stb_o, 0);
    chk("rst_wr_reg", wr_reg_o, 0);
    chk("rst_wr_dat", wr_dat_o, 0);
    chk("rst_frame_err", frame_err_o, 0);
    chk("rst_state", dbg_state_o, 0);
    rst_i = 1'b0;
    idle(4);

    // Read PHY ID1
    run_frame(32, 2'b10, 5'd1, 5'd2, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("id1_oe_ta1", oe1, 0);
    chk("id1_oe_ta2", oe2, 1);
    chk("id1_data", rd, 16'h001C);
    idle(6);
    chk("id1_oe_after", mdio_oe, 0);

    // Write ANAR then read it back
    stb0 = stb_cnt;
    run_frame(32, 2'b01, 5'd1, 5'd4, 16'h0DE1, -1, rd, oe1, oe2, oep, oeq);
    idle(4);
    chk("wr4_stb_count", stb_cnt - stb0, 1);
    chk("wr4_reg", wr_reg_o, 4);
    chk("wr4_dat", wr_dat_o, 16'h0DE1);
    run_frame(32, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("rd4_data", rd, 16'h0DE1);
    idle(6);

    // Status registers
    link_i = 1'b1; speed_i = 2'b10; duplex_i = 1'b1;
    run_frame(32, 2'b10, 5'd1, 5'd17, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("physr", rd, 16'hA400);
    idle(6);
    run_frame(32, 2'b10, 5'd1, 5'd1, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("bmsr_link1", rd, exp_bmsr | 16'h0004);
    idle(6);
    link_i = 1'b0;
    run_frame(32, 2'b10, 5'd1, 5'd1, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("bmsr_link0", rd, exp_bmsr);
    idle(6);
    run_frame(32, 2'b10, 5'd1, 5'd7, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("unimpl_reg7", rd, 16'h0000);
    idle(6);

    // Frames to another PHY address stay silent
    stb0 = stb_cnt; oe0 = oe_cnt;
    run_frame(32, 2'b01, 5'd5, 5'd4, 16'h1234, -1, rd, oe1, oe2, oep, oeq);
    run_frame(32, 2'b10, 5'd5, 5'd4, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    idle(6);
    chk("phy5_no_stb", stb_cnt - stb0, 0);
    chk("phy5_no_oe", oe_cnt - oe0, 0);
    run_frame(32, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("phy5_reg4_kept", rd, 16'h0DE1);
    idle(6);

    // Bad opcode, then a good frame
    err0 = err_cnt;
    for (int i = 0; i < 32; i++) mdc_cycle(1'b1, s0, o0);
    mdc_cycle(1'b0, s0, o0); mdc_cycle(1'b1, s0, o0);
    mdc_cycle(1'b1, s0, o0); mdc_cycle(1'b1, s0, o0);
    idle(6);
    chk("op11_err_count", err_cnt - err0, 1);
    run_frame(32, 2'b10, 5'd1, 5'd3, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("id2_after_err", rd, 16'hC915);
    idle(6);

    // Read-only write still strobes
    stb0 = stb_cnt;
    run_frame(32, 2'b01, 5'd1, 5'd2, 16'hFFFF, -1, rd, oe1, oe2, oep, oeq);
    idle(4);
    chk("ro_wr_stb", stb_cnt - stb0, 1);
    run_frame(32, 2'b10, 5'd1, 5'd2, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("ro_id1_kept", rd, 16'h001C);
    idle(6);

    // Soft reset via BMCR[15]
    run_frame(32, 2'b01, 5'd1, 5'd0, 16'h8000, -1, rd, oe1, oe2, oep, oeq);
    run_frame(32, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("srst_bit15_set", rd[15], 1);
    idle(SRST + 200);
    run_frame(32, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("srst_bmcr_done", rd, 16'h1140);
    idle(6);
    run_frame(32, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("srst_anar_reset", rd, 16'h01E1);
    idle(6);

    // Reset in the middle of read data
    run_frame(32, 2'b01, 5'd1, 5'd9, 16'h0F0F, -1, rd, oe1, oe2, oep, oeq);
    idle(6);
    run_frame(32, 2'b10, 5'd1, 5'd9, 16'h0, 7, rd, oe1, oe2, oep, oeq);
    chk("abort_oe_before", oep, 1);
    chk("abort_oe_after", oeq, 0);
    idle(8);
    run_frame(32, 2'b10, 5'd1, 5'd9, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("abort_gbcr_reset", rd, 16'h0200);
    idle(6);

    // Back-to-back frames, second without preamble
    stb0 = stb_cnt;
    run_frame(32, 2'b01, 5'd1, 5'd9, 16'h0AAA, -1, rd, oe1, oe2, oep, oeq);
    run_frame(0, 2'b01, 5'd1, 5'd4, 16'h0BBB, -1, rd, oe1, oe2, oep, oeq);
    idle(6);
    chk("b2b_stb_count", stb_cnt - stb0, exp_b2b);
    run_frame(32, 2'b10, 5'd1, 5'd9, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("b2b_reg9", rd, 16'h0AAA);
    idle(6);
    run_frame(32, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd, oe1, oe2, oep, oeq);
    chk("b2b_reg4", rd, exp_reg4);
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
